store_write_buffer: RTL and testbench

- FIFO write buffer downstream of the data cache on the write-through path.
- Accepts byte (sb) and word stores from the cache's write port, queues them, and drains them to the byte-addressed backing memory over a valid/ready handshake.
- Lets the cache keep hitting while memory is slow.
- Exposes a word-address match so that loads to addresses with pending stores are stalled.

---
 rtl/store_write_buffer.sv | 146 ++++++++++++++
 tb/tb_store_write_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Write-through store buffer: queues byte/word stores from the data cache and
// drains them in order to memory. Optional coalescing via STORE_BUF_COALESCE_EN.
module store_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [ADDR_W-1:0]        enq_addr,
    input  logic [31:0]              enq_data,
    input  logic                     enq_sb,
    output logic                     misalign_err,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_data,
    output logic [3:0]               mem_byte_en,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     lookup_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned WAW = ADDR_W - 2;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [WAW-1:0] wa_q   [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [3:0]     be_q   [DEPTH];

    ptr_t head_q, head_d, tail_q, tail_d;
    cnt_t count_q, count_d;
    logic misalign_q, misalign_d;

    logic [WAW-1:0] enq_wa;
    logic [31:0]    enq_wdata;
    logic [3:0]     enq_be;
    logic           misaligned, enq_take, merge, alloc, pop;
    logic           unused_lookup_lsb;

    assign unused_lookup_lsb = ^lookup_addr[1:0];

    assign full          = (count_q == cnt_t'(DEPTH));
    assign empty         = (count_q == '0);
    assign enq_ready     = ~full;
    assign mem_req_valid = ~empty;
    assign count         = count_q;
    assign misalign_err  = misalign_q;

    assign mem_addr    = {wa_q[head_q], 2'b00};
    assign mem_data    = data_q[head_q];
    assign mem_byte_en = be_q[head_q];

    assign enq_wa     = enq_addr[ADDR_W-1:2];
    assign misaligned = ~enq_sb && (enq_addr[1:0] != 2'b00);
    assign enq_take   = enq_valid && enq_ready && ~misaligned;
    assign enq_be     = enq_sb ? (4'b0001 << enq_addr[1:0]) : 4'b1111;
    assign enq_wdata  = enq_sb ? {4{enq_data[7:0]}} : enq_data;
    assign pop        = mem_req_valid && mem_req_ready;

`ifdef STORE_BUF_COALESCE_EN
    ptr_t        newest;
    logic [31:0] merged_data;

    assign newest = tail_q - ptr_t'(1);
    // count >= 2 keeps the head under presentation out of reach of a merge.
    assign merge  = enq_take && (count_q >= cnt_t'(2)) && (wa_q[newest] == enq_wa);

    always_comb begin
        merged_data = data_q[newest];
        for (int unsigned j = 0; j < 4; j++) begin
            if (enq_be[j]) begin
                merged_data[8*j +: 8] = enq_wdata[8*j +: 8];
            end
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign alloc = enq_take && ~merge;

    always_comb begin
        head_d     = pop ? head_q + ptr_t'(1) : head_q;
        tail_d     = alloc ? tail_q + ptr_t'(1) : tail_q;
        misalign_d = enq_valid && enq_ready && misaligned;
        count_d    = count_q;
        unique case ({alloc, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Entry payload needs no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clock) begin
        if (alloc) begin
            wa_q[tail_q]   <= enq_wa;
            data_q[tail_q] <= enq_wdata;
            be_q[tail_q]   <= enq_be;
        end
`ifdef STORE_BUF_COALESCE_EN
        else if (merge) begin
            be_q[newest]   <= be_q[newest] | enq_be;
            data_q[newest] <= merged_data;
        end
`endif
    end

    function automatic logic occupied(input ptr_t idx, input ptr_t head, input cnt_t cnt);
        ptr_t off;
        off = idx - head;
        return {1'b0, off} < cnt;
    endfunction

    always_comb begin
        lookup_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied(ptr_t'(i), head_q, count_q) &&
                (wa_q[i] == lookup_addr[ADDR_W-1:2])) begin
                lookup_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed + random bench for store_write_buffer against a queue-based model.
// Honours STORE_BUF_COALESCE_EN the same way the design does.
module tb_store_write_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enq_valid, enq_ready, enq_sb, misalign_err;
    logic [31:0] enq_addr, enq_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_data, lookup_addr;
    logic [3:0]  mem_byte_en;
    logic        lookup_hit, full, empty;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    logic mis_exp = 1'b0;

`ifdef STORE_BUF_COALESCE_EN
    localparam int unsigned EXP_COAL_CNT = 2;
    localparam logic [3:0]  EXP_COAL_BE  = 4'b0011;
`else
    localparam int unsigned EXP_COAL_CNT = 3;
    localparam logic [3:0]  EXP_COAL_BE  = 4'b0001;
`endif

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_addr     (enq_addr),
        .enq_data     (enq_data),
        .enq_sb       (enq_sb),
        .misalign_err (misalign_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_byte_en  (mem_byte_en),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        logic hit;
        hit = 1'b0;
        foreach (q[i]) if (q[i].wa == lookup_addr[31:2]) hit = 1'b1;
        chk("m_valid", 32'(mem_req_valid), 32'(q.size() != 0));
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_full", 32'(full), 32'(q.size() == DEPTH));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_enq_ready", 32'(enq_ready), 32'(q.size() != DEPTH));
        chk("m_misalign", 32'(misalign_err), 32'(mis_exp));
        chk("m_lookup", 32'(lookup_hit), 32'(hit));
        if (q.size() != 0) begin
            chk("m_addr", mem_addr, {q[0].wa, 2'b00});
            chk("m_data", mem_data, q[0].d);
            chk("m_be", 32'(mem_byte_en), 32'(q[0].be));
        end
    endtask

    task automatic model_edge();
        ent_t e;
        logic acc, do_pop, mrg;
        if (!reset) begin
            q.delete();
            mis_exp = 1'b0;
            return;
        end
        acc     = enq_valid && (q.size() < DEPTH) && (enq_sb || enq_addr[1:0] == 2'b00);
        mis_exp = enq_valid && (q.size() < DEPTH) && !enq_sb && (enq_addr[1:0] != 2'b00);
        do_pop  = (q.size() != 0) && mem_req_ready;
        e.wa = enq_addr[31:2];
        e.be = enq_sb ? (4'b0001 << enq_addr[1:0]) : 4'hF;
        e.d  = enq_sb ? {4{enq_data[7:0]}} : enq_data;
        mrg  = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        if (acc && q.size() >= 2 && q[q.size()-1].wa == e.wa) begin
            ent_t t;
            t = q[q.size()-1];
            for (int j = 0; j < 4; j++) if (e.be[j]) t.d[8*j +: 8] = e.d[8*j +: 8];
            t.be = t.be | e.be;
            q[q.size()-1] = t;
            mrg = 1'b1;
        end
`endif
        if (do_pop) void'(q.pop_front());
        if (acc && !mrg) q.push_back(e);
    endtask

    // One clock: drive at negedge, check model before the edge, advance model at the edge.
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic sb, input logic rdy, input logic [31:0] la,
                       input logic rst_n);
        @(negedge clock);
        enq_valid     = v;
        enq_addr      = a;
        enq_data      = d;
        enq_sb        = sb;
        mem_req_ready = rdy;
        lookup_addr   = la;
        reset         = rst_n;
        #1;
        cmp_model();
        @(posedge clock);
        model_edge();
        #2;
    endtask

    initial begin
        reset = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_sb = 1'b0;
        mem_req_ready = 1'b0; lookup_addr = '0;

        cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(mem_req_valid), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_lookup", 32'(lookup_hit), 0);

        // Word store, held by memory.
        cyc(1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 0, 1'b1);
        lookup_addr = 32'h23; #1;
        chk("w_count", 32'(count), 1);
        chk("w_addr", mem_addr, 32'h20);
        chk("w_be", 32'(mem_byte_en), 32'hF);
        chk("w_data", mem_data, 32'hDEADBEEF);
        chk("w_hit", 32'(lookup_hit), 1);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 32'h23, 1'b1);
        chk("w_pop_empty", 32'(empty), 1);
        chk("w_pop_hit", 32'(lookup_hit), 0);

        // Byte store lane positioning.
        cyc(1'b1, 32'h06, 32'h000000AB, 1'b1, 1'b0, 0, 1'b1);
        chk("sb_addr", mem_addr, 32'h04);
        chk("sb_be", 32'(mem_byte_en), 32'b0100);
        chk("sb_data", mem_data, 32'hABABABAB);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b1);

        // Fill, reject when full, drain in order, then wrap.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 0, 1'b1);
        chk("fill_full", 32'(full), 1);
        chk("fill_enq_ready", 32'(enq_ready), 0);
        cyc(1'b1, 32'h10, 32'h5555AAAA, 1'b0, 1'b0, 0, 1'b1);
        chk("fill_fifth", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", mem_addr, 32'(i * 4));
            cyc(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b1);
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(1'b1, 32'h30, 32'h11112222, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b1, 32'h34, 32'h33334444, 1'b0, 1'b0, 0, 1'b1);
        chk("wrap_count", 32'(count), 2);
        chk("wrap_head", mem_addr, 32'h30);

        // Simultaneous enqueue and pop, then reset mid-drain.
        cyc(1'b1, 32'h38, 32'h55556666, 1'b0, 1'b1, 0, 1'b1);
        chk("simul_count", 32'(count), 2);
        chk("simul_head", mem_addr, 32'h34);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_valid", 32'(mem_req_valid), 0);

        // Misaligned word store.
        cyc(1'b1, 32'h11, 32'hCAFEF00D, 1'b0, 1'b0, 0, 1'b1);
        chk("mis_pulse", 32'(misalign_err), 1);
        chk("mis_count", 32'(count), 0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("mis_clear", 32'(misalign_err), 0);

        // Coalescing into the newest entry.
        cyc(1'b1, 32'h40, 32'h00000011, 1'b1, 1'b0, 0, 1'b1);
        cyc(1'b1, 32'h100, 32'h00000022, 1'b1, 1'b0, 0, 1'b1);
        cyc(1'b1, 32'h101, 32'h00000077, 1'b1, 1'b0, 0, 1'b1);
        chk("coal_count", 32'(count), EXP_COAL_CNT);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b1);
        chk("coal_addr", mem_addr, 32'h100);
        chk("coal_be", 32'(mem_byte_en), 32'(EXP_COAL_BE));
        chk("coal_byte0", 32'(mem_data[7:0]), 32'h22);
        while (count != 0 && total < 5000) cyc(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b1);

        // Random traffic over a small address window to provoke hits and merges.
        for (int n = 0; n < 600; n++) begin
            cyc(1'($urandom_range(0, 2) != 0), 32'($urandom_range(0, 47)), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                32'($urandom_range(0, 47)), 1'($urandom_range(0, 63) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
